// File: rtl/id_ex_if.sv
// id_ex_if: decode-side operands, write-back bus and registered execute-side outputs of the ID/EX stage
interface id_ex_if;
  logic [31:0] rsD, rtD, imm_extD;
  logic [4:0] rs_numD, rt_numD, dst_numD;
  logic [15:0] ctrlD;
  logic [31:0] wb_data;
  logic [4:0] WriteRegW;
  logic RegWriteW;
  logic flushE;
  logic [31:0] rsE, rtE, imm_extE;
  logic [4:0] rs_numE, rt_numE, dst_numE;
  logic [15:0] ctrlE;
  logic validE;
  logic stallD;
  logic [31:0] stall_cnt;
  modport master (
    output rsD, rtD, imm_extD, rs_numD, rt_numD, dst_numD, ctrlD, wb_data, WriteRegW, RegWriteW, flushE,
    input rsE, rtE, imm_extE, rs_numE, rt_numE, dst_numE, ctrlE, validE, stallD, stall_cnt
  );
  modport slave (
    input rsD, rtD, imm_extD, rs_numD, rt_numD, dst_numD, ctrlD, wb_data, WriteRegW, RegWriteW, flushE,
    output rsE, rtE, imm_extE, rs_numE, rt_numE, dst_numE, ctrlE, validE, stallD, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and stall counter; WB_BYPASS_EN enables write-back bypass into rsE/rtE
module id_ex_stage (
  input logic CLK,
  input logic reset,
  id_ex_if.slave p
);
  typedef enum logic {RUN, BUBBLE} state_t;
  state_t state, state_nxt;
  logic hazard, bubble;
  logic [31:0] rs_in, rt_in;
  // load in E writing a register that the decode instruction reads
  always_comb hazard = p.validE & p.ctrlE[1] & p.ctrlE[0] & (p.dst_numE != 5'd0) &
                       ((p.dst_numE == p.rs_numD) | (p.dst_numE == p.rt_numD));
`ifdef WB_BYPASS_EN
  // take the value being written back this cycle when it targets a source register
  always_comb begin
    rs_in = (p.RegWriteW & (p.WriteRegW != 5'd0) & (p.WriteRegW == p.rs_numD)) ? p.wb_data : p.rsD;
    rt_in = (p.RegWriteW & (p.WriteRegW != 5'd0) & (p.WriteRegW == p.rt_numD)) ? p.wb_data : p.rtD;
  end
`else
  // operands come straight from the register file read
  always_comb begin
    rs_in = p.rsD;
    rt_in = p.rtD;
  end
`endif
  // state register
  always_ff @(posedge CLK) state <= reset ? RUN : state_nxt;
  // a bubble always lasts one cycle
  always_comb state_nxt = (state == RUN && hazard) ? BUBBLE : RUN;
  // freeze request and bubble select
  always_comb begin
    p.stallD = hazard;
    bubble = hazard | p.flushE;
  end
  // execute-stage register: cleared on reset, bubble on hazard/flush, otherwise capture decode
  always_ff @(posedge CLK) begin
    if (reset || bubble) begin
      p.rsE <= '0;
      p.rtE <= '0;
      p.imm_extE <= '0;
      p.rs_numE <= '0;
      p.rt_numE <= '0;
      p.dst_numE <= '0;
      p.ctrlE <= '0;
      p.validE <= 1'b0;
    end else begin
      p.rsE <= rs_in;
      p.rtE <= rt_in;
      p.imm_extE <= p.imm_extD;
      p.rs_numE <= p.rs_numD;
      p.rt_numE <= p.rt_numD;
      p.dst_numE <= p.dst_numD;
      p.ctrlE <= p.ctrlD;
      p.validE <= 1'b1;
    end
  end
  // count load-use bubbles only, saturating
  always_ff @(posedge CLK) begin
    if (reset) p.stall_cnt <= '0;
    else if (hazard && p.stall_cnt != '1) p.stall_cnt <= p.stall_cnt + 32'd1;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors for id_ex_stage with hand-computed expectations
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic reset;
  int n_vec = 0;
  int n_err = 0;
  id_ex_if bus ();
  id_ex_stage dut (.CLK(clk), .reset(reset), .p(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] rs, input logic [4:0] rsn, input logic [4:0] rtn,
                       input logic [4:0] dst, input logic [15:0] ctrl);
    bus.rsD = rs;
    bus.rtD = rs + 32'h100;
    bus.imm_extD = rs + 32'h200;
    bus.rs_numD = rsn;
    bus.rt_numD = rtn;
    bus.dst_numD = dst;
    bus.ctrlD = ctrl;
  endtask
  initial begin
    reset = 1'b1;
    bus.flushE = 1'b0;
    bus.RegWriteW = 1'b0;
    bus.WriteRegW = 5'd0;
    bus.wb_data = 32'h0;
    drive(32'h33, 5'd1, 5'd2, 5'd3, 16'h3);
    tick();
    tick();
    check("rst_rsE", bus.rsE, 32'h0);
    check("rst_ctrlE", {16'h0, bus.ctrlE}, 32'h0);
    check("rst_validE", {31'h0, bus.validE}, 32'h0);
    check("rst_cnt", bus.stall_cnt, 32'h0);
    check("rst_stallD", {31'h0, bus.stallD}, 32'h0);
    reset = 1'b0;
    drive(32'h5, 5'd1, 5'd2, 5'd3, 16'h1);
    #1 check("post_rst_stallD", {31'h0, bus.stallD}, 32'h0);
    tick();
    check("lat_rsE", bus.rsE, 32'h5);
    check("lat_rtE", bus.rtE, 32'h105);
    check("lat_imm", bus.imm_extE, 32'h205);
    check("lat_dst", {27'h0, bus.dst_numE}, 32'h3);
    check("lat_ctrlE", {16'h0, bus.ctrlE}, 32'h1);
    check("lat_validE", {31'h0, bus.validE}, 32'h1);
    check("lat_cnt", bus.stall_cnt, 32'h0);
    drive(32'h7, 5'd4, 5'd5, 5'd8, 16'h3);
    tick();
    check("load_ctrlE", {16'h0, bus.ctrlE}, 32'h3);
    drive(32'h11, 5'd8, 5'd1, 5'd10, 16'h1);
    #1 check("lu_stallD", {31'h0, bus.stallD}, 32'h1);
    tick();
    check("lu_validE", {31'h0, bus.validE}, 32'h0);
    check("lu_ctrlE", {16'h0, bus.ctrlE}, 32'h0);
    check("lu_rsE", bus.rsE, 32'h0);
    check("lu_cnt", bus.stall_cnt, 32'h1);
    check("lu_stallD_after", {31'h0, bus.stallD}, 32'h0);
    tick();
    check("lu_resume_valid", {31'h0, bus.validE}, 32'h1);
    check("lu_resume_rsE", bus.rsE, 32'h11);
    check("lu_resume_dst", {27'h0, bus.dst_numE}, 32'ha);
    drive(32'h20, 5'd4, 5'd5, 5'd0, 16'h3);
    tick();
    drive(32'h21, 5'd0, 5'd0, 5'd12, 16'h1);
    #1 check("r0_stallD", {31'h0, bus.stallD}, 32'h0);
    tick();
    check("r0_validE", {31'h0, bus.validE}, 32'h1);
    check("r0_rsE", bus.rsE, 32'h21);
    check("r0_cnt", bus.stall_cnt, 32'h1);
    drive(32'h22, 5'd3, 5'd4, 5'd5, 16'h1);
    bus.flushE = 1'b1;
    #1 check("fl_stallD", {31'h0, bus.stallD}, 32'h0);
    tick();
    bus.flushE = 1'b0;
    check("fl_validE", {31'h0, bus.validE}, 32'h0);
    check("fl_rsE", bus.rsE, 32'h0);
    check("fl_cnt", bus.stall_cnt, 32'h1);
    drive(32'h23, 5'd1, 5'd2, 5'd8, 16'h3);
    tick();
    check("fh_load_valid", {31'h0, bus.validE}, 32'h1);
    drive(32'h24, 5'd0, 5'd8, 5'd6, 16'h1);
    bus.flushE = 1'b1;
    #1 check("fh_stallD", {31'h0, bus.stallD}, 32'h1);
    tick();
    bus.flushE = 1'b0;
    check("fh_validE", {31'h0, bus.validE}, 32'h0);
    check("fh_cnt", bus.stall_cnt, 32'h2);
    drive(32'h9, 5'd9, 5'd9, 5'd7, 16'h1);
    bus.rtD = 32'h9;
    bus.RegWriteW = 1'b1;
    bus.WriteRegW = 5'd9;
    bus.wb_data = 32'hDEAD_BEEF;
    tick();
`ifdef WB_BYPASS_EN
    check("byp_rsE", bus.rsE, 32'hDEAD_BEEF);
    check("byp_rtE", bus.rtE, 32'hDEAD_BEEF);
`else
    check("byp_rsE", bus.rsE, 32'h9);
    check("byp_rtE", bus.rtE, 32'h9);
`endif
    drive(32'h44, 5'd0, 5'd1, 5'd7, 16'h1);
    bus.WriteRegW = 5'd0;
    tick();
    check("byp_r0_rsE", bus.rsE, 32'h44);
    bus.RegWriteW = 1'b0;
    drive(32'h25, 5'd1, 5'd2, 5'd8, 16'h3);
    tick();
    drive(32'h26, 5'd8, 5'd2, 5'd4, 16'h1);
    tick();
    check("rb_bubble_valid", {31'h0, bus.validE}, 32'h0);
    check("rb_bubble_cnt", bus.stall_cnt, 32'h3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rb_validE", {31'h0, bus.validE}, 32'h0);
    check("rb_ctrlE", {16'h0, bus.ctrlE}, 32'h0);
    check("rb_rsE", bus.rsE, 32'h0);
    check("rb_cnt", bus.stall_cnt, 32'h0);
    check("rb_stallD", {31'h0, bus.stallD}, 32'h0);
    tick();
    check("rb_run_valid", {31'h0, bus.validE}, 32'h1);
    check("rb_run_rsE", bus.rsE, 32'h26);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port CLK  input  1  rising-edge clock; the single clock of the block.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-003 SHALL have ports rsD, rtD  input  32 each  decode-stage register-file read data.
REQ-004 SHALL have ports rs_numD, rt_numD, dst_numD  input  5 each  source and destination register numbers in decode.
REQ-005 SHALL have port imm_extD  input  32  sign/zero-extended immediate from decode.
REQ-006 SHALL have port ctrlD  input  16  decode control bundle: bit0 RegWrite, bit1 MemRead (load), bits15:2 passed through unchanged.
REQ-007 SHALL have ports wb_data  input  32, WriteRegW  input  5, RegWriteW  input  1  write-back bus, same as the register file's.
REQ-008 SHALL have port flushE  input  1  squash request from branch/jump resolution.
REQ-009 SHALL have ports rsE, rtE, imm_extE  output  32 each, and rs_numE, rt_numE, dst_numE  output  5 each  registered execute-stage operands.
REQ-010 SHALL have port ctrlE  output  16  registered control bundle.
REQ-011 SHALL have port validE  output  1  high when E holds a real instruction.
REQ-012 SHALL have port stallD  output  1  combinational freeze request to PC and IF/ID.
REQ-013 SHALL have port stall_cnt  output  32  count of load-use bubbles inserted.

Function
REQ-014 SHALL assert hazard = validE & ctrlE[1] & ctrlE[0] & (dst_numE != 0) & (dst_numE == rs_numD | dst_numE == rt_numD); stallD = hazard, combinational, same cycle.
REQ-015 SHALL use a two-state machine: RUN and BUBBLE; RUN->BUBBLE on rising CLK when hazard=1; BUBBLE->RUN unconditionally next rising CLK.
REQ-016 SHALL, on rising CLK when hazard=1 or flushE=1, load E with a bubble: validE=0, ctrlE=0, all other E outputs 0.
REQ-017 SHALL otherwise, on rising CLK, latch all D inputs into E with validE=1; latency from D to E is exactly one cycle.
REQ-018 SHALL never assert hazard in state BUBBLE (validE=0 there guarantees it); one load-use stall lasts exactly one cycle.
REQ-019 SHALL increment stall_cnt by 1 on each bubble caused by hazard, saturating at 32'hFFFF_FFFF; flush-only bubbles do not count.
REQ-020 SHALL, when flushE and hazard coincide, insert one bubble, keep stallD=1 that cycle, and increment stall_cnt once.
REQ-021 SHALL treat register 0 as never hazarding and never bypassed.

Reset
REQ-022 SHALL, on rising CLK with reset=1, clear every registered output (rsE..ctrlE, validE, stall_cnt) to 0 and enter RUN.
REQ-023 SHALL give reset priority over flushE, hazard and normal latching, including mid-stall (BUBBLE->RUN).
REQ-024 SHALL drive stallD=0 in the cycle after reset, since validE=0.

Configuration
REQ-025 SHALL honour macro WB_BYPASS_EN: when defined, rsE latches wb_data instead of rsD when RegWriteW=1 & WriteRegW!=0 & WriteRegW==rs_numD (same rule for rtE/rt_numD); when undefined, rsE/rtE always latch rsD/rtD.

Verification
REQ-026 SHALL cover: reset=1 for 2 cycles, then rsD=32'h5, ctrlD=16'h1 -> after 1 cycle rsE=5, ctrlE=1, validE=1, stall_cnt=0.
REQ-027 SHALL cover: E holds load (ctrlE=3, dst_numE=8), rs_numD=8 -> stallD=1 same cycle; next cycle validE=0, ctrlE=0, stall_cnt=1, stallD=0; following cycle decode instruction latched with validE=1.
REQ-028 SHALL cover: E holds load with dst_numE=0 and rs_numD=0 -> stallD=0, no bubble.
REQ-029 SHALL cover: flushE=1 with no hazard -> next cycle validE=0, stall_cnt unchanged; flushE=1 with hazard -> one bubble, stall_cnt +1.
REQ-030 SHALL cover (WB_BYPASS_EN defined): RegWriteW=1, WriteRegW=9, wb_data=32'hDEAD_BEEF, rs_numD=9, rsD=32'h9 -> rsE=32'hDEAD_BEEF; same stimulus with macro undefined -> rsE=32'h9.
REQ-031 SHALL cover: reset=1 asserted while in BUBBLE -> next cycle all outputs 0, state RUN, stall_cnt=0.
